// File: rtl/cmp_pkg.sv
// Shared constants and types for the iterative comparator: flag bit positions,
// controller state encoding and the signed-mode selector value.
package cmp_pkg;

   localparam int FLAG_W   = 5;
   localparam int FLAG_EQ  = 4;
   localparam int FLAG_LT  = 3;
   localparam int FLAG_LTU = 2;
   localparam int FLAG_GE  = 1;
   localparam int FLAG_GEU = 0;

   localparam logic MODE_SIGNED = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/cmp_chunk.sv
// Combinational unsigned compare of one operand slice; the iterative
// controller feeds it one chunk per cycle, MSB chunk first.
module cmp_chunk #(
   parameter int W = 16
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic         eq_o,
   output logic         lt_o
);

   assign eq_o = (a_i == b_i);
   assign lt_o = (a_i < b_i);

endmodule

// File: rtl/cmp_iter.sv
// Iterative signed/unsigned comparator: walks CHUNK_WIDTH-bit slices from the
// MSB end, latching the first difference, then publishes flags and min/max.
module cmp_iter
   import cmp_pkg::*;
#(
   parameter int DATA_WIDTH  = 64,
   parameter int CHUNK_WIDTH = 16,
   parameter int NUM_CHUNKS  = DATA_WIDTH / CHUNK_WIDTH
) (
   input  logic                  in_clk,
   input  logic                  in_rst,
   input  logic                  in_valid,
   output logic                  out_ready,
   input  logic [DATA_WIDTH-1:0] in_numA,
   input  logic [DATA_WIDTH-1:0] in_numB,
   input  logic                  in_signed,
   output logic                  out_valid,
   input  logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_result,
   output logic [DATA_WIDTH-1:0] out_min,
   output logic [DATA_WIDTH-1:0] out_max,
   output logic [FLAG_W-1:0]     out_flag
);

   localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam int MUX_N = 1 << CNT_W;

   state_e                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic                    mode_q, mode_d;
   logic                    sign_a_q, sign_a_d, sign_b_q, sign_b_d;
   logic                    decided_q, decided_d;
   logic                    lt_u_q, lt_u_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   result_q, result_d;
   logic [DATA_WIDTH-1:0]   min_q, min_d, max_q, max_d;
   logic [FLAG_W-1:0]       flag_q, flag_d;

   logic [CHUNK_WIDTH-1:0]  chunk_a [MUX_N];
   logic [CHUNK_WIDTH-1:0]  chunk_b [MUX_N];
   logic                    chunk_eq, chunk_lt;
   logic                    decided_nx, lt_u_nx, lt_s_nx, lt_mode;
   logic [FLAG_W-1:0]       flag_nx;

   // Mux table padded to a power of two so the counter indexes it exactly.
   genvar gi;
   generate
      for (gi = 0; gi < MUX_N; gi++) begin : g_chunk
         if (gi < NUM_CHUNKS) begin : g_live
            assign chunk_a[gi] = a_q[gi*CHUNK_WIDTH +: CHUNK_WIDTH];
            assign chunk_b[gi] = b_q[gi*CHUNK_WIDTH +: CHUNK_WIDTH];
         end else begin : g_pad
            assign chunk_a[gi] = '0;
            assign chunk_b[gi] = '0;
         end
      end
   endgenerate

   cmp_chunk #(.W(CHUNK_WIDTH)) u_chunk (
      .a_i  (chunk_a[cnt_q]),
      .b_i  (chunk_b[cnt_q]),
      .eq_o (chunk_eq),
      .lt_o (chunk_lt)
   );

   // Signed order needs only the captured sign bits: differing signs decide
   // outright, equal signs reduce to the unsigned order.
   always_comb begin
      decided_nx = decided_q | ~chunk_eq;
      lt_u_nx    = decided_q ? lt_u_q : chunk_lt;
      lt_s_nx    = (sign_a_q != sign_b_q) ? sign_a_q : lt_u_nx;
      lt_mode    = (mode_q == MODE_SIGNED) ? lt_s_nx : lt_u_nx;
      flag_nx            = '0;
      flag_nx[FLAG_EQ]   = ~decided_nx;
      flag_nx[FLAG_LT]   = lt_s_nx;
      flag_nx[FLAG_LTU]  = lt_u_nx;
      flag_nx[FLAG_GE]   = ~lt_s_nx;
      flag_nx[FLAG_GEU]  = ~lt_u_nx;
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      mode_d    = mode_q;
      sign_a_d  = sign_a_q;
      sign_b_d  = sign_b_q;
      decided_d = decided_q;
      lt_u_d    = lt_u_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      min_d     = min_q;
      max_d     = max_q;
      flag_d    = flag_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d       = in_numA;
               b_d       = in_numB;
               mode_d    = in_signed;
               sign_a_d  = in_numA[DATA_WIDTH-1];
               sign_b_d  = in_numB[DATA_WIDTH-1];
               decided_d = 1'b0;
               lt_u_d    = 1'b0;
               cnt_d     = CNT_W'(NUM_CHUNKS - 1);
               state_d   = BUSY;
            end
         end
         BUSY: begin
            decided_d = decided_nx;
            lt_u_d    = lt_u_nx;
            if (cnt_q == '0) begin
               result_d = DATA_WIDTH'(lt_mode);
               min_d    = lt_mode ? a_q : b_q;
               max_d    = lt_mode ? b_q : a_q;
               flag_d   = flag_nx;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            if (in_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         mode_q    <= 1'b0;
         sign_a_q  <= 1'b0;
         sign_b_q  <= 1'b0;
         decided_q <= 1'b0;
         lt_u_q    <= 1'b0;
         cnt_q     <= '0;
         result_q  <= '0;
         min_q     <= '0;
         max_q     <= '0;
         flag_q    <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         mode_q    <= mode_d;
         sign_a_q  <= sign_a_d;
         sign_b_q  <= sign_b_d;
         decided_q <= decided_d;
         lt_u_q    <= lt_u_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         min_q     <= min_d;
         max_q     <= max_d;
         flag_q    <= flag_d;
      end
   end

   assign out_ready  = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign out_result = result_q;
   assign out_min    = min_q;
   assign out_max    = max_q;
   assign out_flag   = flag_q;

endmodule

// File: tb/tb_cmp_iter.sv
// Scoreboard bench for cmp_iter: 64/16 main instance plus 8/8 and 8/2
// instances for the single-chunk and narrow-chunk corners.
module tb_cmp_iter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid, in_signed, in_ready;
   logic [63:0] in_numA, in_numB;
   logic        out_ready, out_valid;
   logic [63:0] out_result, out_min, out_max;
   logic [4:0]  out_flag;

   cmp_iter #(.DATA_WIDTH(64), .CHUNK_WIDTH(16)) dut (
      .in_clk(clk), .in_rst(rst), .in_valid(in_valid), .out_ready(out_ready),
      .in_numA(in_numA), .in_numB(in_numB), .in_signed(in_signed),
      .out_valid(out_valid), .in_ready(in_ready), .out_result(out_result),
      .out_min(out_min), .out_max(out_max), .out_flag(out_flag)
   );

   logic       v8, s8;
   logic [7:0] a8, b8;
   logic       rdy_a, val_a, rdy_b, val_b;
   logic [7:0] res_a, mn_a, mx_a, res_b, mn_b, mx_b;
   logic [4:0] fl_a, fl_b;

   cmp_iter #(.DATA_WIDTH(8), .CHUNK_WIDTH(8)) u8a (
      .in_clk(clk), .in_rst(rst), .in_valid(v8), .out_ready(rdy_a),
      .in_numA(a8), .in_numB(b8), .in_signed(s8), .out_valid(val_a),
      .in_ready(1'b1), .out_result(res_a), .out_min(mn_a), .out_max(mx_a),
      .out_flag(fl_a)
   );

   cmp_iter #(.DATA_WIDTH(8), .CHUNK_WIDTH(2)) u8b (
      .in_clk(clk), .in_rst(rst), .in_valid(v8), .out_ready(rdy_b),
      .in_numA(a8), .in_numB(b8), .in_signed(s8), .out_valid(val_b),
      .in_ready(1'b1), .out_result(res_b), .out_min(mn_b), .out_max(mx_b),
      .out_flag(fl_b)
   );

   typedef struct {
      logic [63:0] a, b, res, mn, mx;
      logic [4:0]  flag;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   logic prev_v  = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compare each new result against the oldest expectation.
   always @(negedge clk) begin
      if (out_valid && !prev_v) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result: got flag %b with no request outstanding", out_flag);
         end else begin
            e = sb.pop_front();
            $display("[TB] txn A=%h B=%h flag=%b res=%0d min=%h max=%h lat=%0d",
                     e.a, e.b, out_flag, out_result, out_min, out_max, cyc - e.acc);
            chk("flag",    64'(out_flag), 64'(e.flag));
            chk("result",  out_result, e.res);
            chk("min",     out_min, e.mn);
            chk("max",     out_max, e.mx);
            chk("latency", 64'(cyc - e.acc), 64'(e.lat));
         end
      end
      prev_v = out_valid;
   end

   task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic s,
                        input logic [63:0] er, input logic [63:0] emn, input logic [63:0] emx,
                        input logic [4:0] ef, input bit push);
      int t = 0;
      @(negedge clk);
      while (!out_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("accept_ready", 64'(out_ready), 64'd1);
      in_valid  = 1'b1;
      in_numA   = a;
      in_numB   = b;
      in_signed = s;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (push) sb.push_back('{a, b, er, emn, emx, ef, 4, cyc});
      in_numA = ~a;
      in_numB = ~b;
   endtask

   task automatic wait_idle();
      int t = 0;
      @(negedge clk);
      while (!out_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("wait_idle", 64'(out_ready), 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat_a, lat_b, t;
      logic [4:0] cfa, cfb;
      logic [7:0] cra, crb, cma, cmb, cxa, cxb;

      rst = 1'b1; in_valid = 1'b0; in_ready = 1'b1; in_signed = 1'b0;
      in_numA = '0; in_numB = '0;
      v8 = 1'b0; s8 = 1'b0; a8 = '0; b8 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready",  64'(out_ready), 64'd1);
      chk("rst_valid",  64'(out_valid), 64'd0);
      chk("rst_flag",   64'(out_flag), 64'd0);
      chk("rst_result", out_result, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      issue(64'd5, 64'd5, 1'b1, 64'd0, 64'd5, 64'd5, 5'b10011, 1'b1);
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'd1,
            64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'b01001, 1'b1);
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0,
            64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'b01001, 1'b1);
      issue(64'h1234_5678_9ABC_0000, 64'h1234_5678_9ABC_0001, 1'b1, 64'd1,
            64'h1234_5678_9ABC_0000, 64'h1234_5678_9ABC_0001, 5'b01100, 1'b1);
      issue(64'h1234_5678_9ABC_0001, 64'h1234_5678_9ABC_0000, 1'b0, 64'd0,
            64'h1234_5678_9ABC_0000, 64'h1234_5678_9ABC_0001, 5'b00011, 1'b1);
      issue(64'h8000_0000_0000_0000, 64'd0, 1'b1, 64'd1,
            64'h8000_0000_0000_0000, 64'd0, 5'b01001, 1'b1);

      // Downstream stall while new requests are offered.
      wait_idle();
      in_ready = 1'b0;
      issue(64'h10, 64'h20, 1'b0, 64'd1, 64'h10, 64'h20, 5'b01100, 1'b1);
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = (i % 2 == 0);
         in_numA  = 64'(i);
         in_numB  = 64'(i + 100);
         chk("stall_vr",   64'({out_valid, out_ready}), 64'b10);
         chk("stall_flag", 64'(out_flag), 64'(5'b01100));
         chk("stall_min",  out_min, 64'h10);
         chk("stall_max",  out_max, 64'h20);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("release_valid", 64'(out_valid), 64'd0);
      chk("release_ready", 64'(out_ready), 64'd1);
      chk("retain_min",    out_min, 64'h10);

      // Asynchronous abort during the second BUSY cycle.
      issue(64'd9, 64'd2, 1'b0, 64'd0, 64'd0, 64'd0, 5'b00000, 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_valid",  64'(out_valid), 64'd0);
      chk("abort_ready",  64'(out_ready), 64'd1);
      chk("abort_flag",   64'(out_flag), 64'd0);
      chk("abort_min",    out_min, 64'd0);
      chk("abort_max",    out_max, 64'd0);
      chk("abort_result", out_result, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      issue(64'd3, 64'd7, 1'b0, 64'd1, 64'd3, 64'd7, 5'b01100, 1'b1);

      t = 0;
      while (sb.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);

      // Narrow instances: single-chunk and 2-bit chunk variants.
      lat_a = -1; lat_b = -1;
      cfa = '0; cfb = '0; cra = '0; crb = '0; cma = '0; cmb = '0; cxa = '0; cxb = '0;
      @(negedge clk);
      v8 = 1'b1; a8 = 8'h80; b8 = 8'h7F; s8 = 1'b1;
      @(posedge clk);
      #1;
      v8 = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk);
         #1;
         if (val_a && lat_a < 0) begin
            lat_a = c; cfa = fl_a; cra = res_a; cma = mn_a; cxa = mx_a;
         end
         if (val_b && lat_b < 0) begin
            lat_b = c; cfb = fl_b; crb = res_b; cmb = mn_b; cxb = mx_b;
         end
      end
      $display("[TB] txn w8c8 A=80 B=7f flag=%b res=%0d lat=%0d", cfa, cra, lat_a);
      $display("[TB] txn w8c2 A=80 B=7f flag=%b res=%0d lat=%0d", cfb, crb, lat_b);
      chk("w8c8_latency", 64'(lat_a), 64'd1);
      chk("w8c8_flag",    64'(cfa), 64'(5'b01001));
      chk("w8c8_result",  64'(cra), 64'd1);
      chk("w8c8_min",     64'(cma), 64'h80);
      chk("w8c8_max",     64'(cxa), 64'h7F);
      chk("w8c2_latency", 64'(lat_b), 64'd4);
      chk("w8c2_flag",    64'(cfb), 64'(5'b01001));
      chk("w8c2_result",  64'(crb), 64'd1);
      chk("w8c2_min",     64'(cmb), 64'h80);
      chk("w8c2_max",     64'(cxb), 64'h7F);
      chk("w8_ready",     64'({rdy_a, rdy_b}), 64'b11);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cmp_iter.md
Name: cmp_iter

Overview:
Parametrised, iterative signed/unsigned integer comparator for the ALU's multi-cycle path. It compares CHUNK_WIDTH bits per cycle, MSB chunk first, and produces the full flag set plus min/max selection. It uses a valid/ready handshake on both sides. Area scales with CHUNK_WIDTH, not DATA_WIDTH, so wide datapaths close timing without a full-width comparator.

Parameters:
DATA_WIDTH, 64, operand width in bits.
CHUNK_WIDTH, 16, bits compared per cycle. Must divide DATA_WIDTH, range 1..DATA_WIDTH.
NUM_CHUNKS, DATA_WIDTH/CHUNK_WIDTH, derived. Not to be overridden.

Ports:
in_clk  input  1  clock, rising edge.
in_rst  input  1  asynchronous, active-high reset.
in_valid  input  1  request valid.
out_ready  output  1  block can accept a request (high only in IDLE).
in_numA  input  DATA_WIDTH  operand A.
in_numB  input  DATA_WIDTH  operand B.
in_signed  input  1  mode: 1 = two's-complement, 0 = unsigned. Selects out_result and min/max only.
out_valid  output  1  result valid.
in_ready  input  1  downstream accepts result.
out_result  output  DATA_WIDTH  1 if A<B under in_signed mode, else 0 (zero-extended).
out_min  output  DATA_WIDTH  smaller operand under mode.
out_max  output  DATA_WIDTH  larger operand under mode.
out_flag  output  5  [4] EQ, [3] LT signed, [2] LT unsigned, [1] GE signed, [0] GE unsigned.

Behaviour:
- Single clock in_clk. in_rst is asynchronous and active-high. While asserted: state IDLE, out_valid=0, out_result/out_min/out_max/out_flag=0, out_ready=1.
- States:
  - IDLE: out_ready=1. On in_valid: register A, B, mode and both sign bits; clear decided/lt_u; chunk counter=NUM_CHUNKS-1; go to BUSY.
  - BUSY: each cycle, compare chunk[cnt] of A and B (cnt counts down from MSB chunk).
    - If !decided and chunks differ: decided←1, lt_u←(chunkA<chunkB).
    - Chunks after the first difference do not change state.
    - When cnt==0, compute final results and go to DONE. Otherwise decrement cnt.
  - DONE: out_valid=1, outputs stable. On in_ready, go to IDLE; out_valid drops the next cycle.
- Latency: accept edge k; out_valid high after edge k+NUM_CHUNKS. Fixed; no early exit.
- Throughput: one result per NUM_CHUNKS+2 cycles minimum.
- Final flag and result computation:
  - EQ = !decided.
  - LTU = lt_u.
  - LT signed = (signA!=signB) ? signA : lt_u.
  - GE = !LT; GEU = !LTU. GE flags are the true complement of LT and hold on equality.
  - out_result = {0…, LT_mode}.
  - out_min = LT_mode ? A : B; out_max = LT_mode ? B : A. Equal operands give A for both.
- in_valid while not IDLE is ignored; no queueing.
- Operands are captured at accept, so the caller may change inputs afterwards.
- Results are registered and held in DONE regardless of input activity. Outputs retain the last result after returning to IDLE until the next DONE.
- Reset mid-BUSY or mid-DONE aborts the operation with no partial result. The next request after reset behaves normally.
- CHUNK_WIDTH==DATA_WIDTH: one BUSY cycle, latency 1.
- All arithmetic is unsigned on chunk slices. Signed handling uses only the captured sign bits; there is no negation, so the most-negative value is handled correctly.

Decomposition:
- Shared package cmp_pkg:
  - flag bit index constants (FLAG_EQ=4, FLAG_LT=3, FLAG_LTU=2, FLAG_GE=1, FLAG_GEU=0);
  - state encoding (IDLE, BUSY, DONE);
  - mode constant (MODE_SIGNED=1).
- One sub-module, cmp_chunk: combinational CHUNK_WIDTH slice compare with outputs eq and lt. Instantiated once and fed by a counter-indexed mux.

Test Plan:
1. DATA_WIDTH=64, CHUNK_WIDTH=16, A=5, B=5, signed=1 → out_valid exactly 4 cycles after accept; out_flag=5'b10011, out_result=0, out_min=out_max=5.
2. A=64'hFFFF_FFFF_FFFF_FFFF, B=1, signed=1 → flag=5'b01001, out_result=1, out_min=A, out_max=1. Repeat with signed=0 → same flag, out_result=0, out_min=1, out_max=A.
3. A=64'h1234_5678_9ABC_0000, B=64'h1234_5678_9ABC_0001 (LSB chunk decides) → flag=5'b01100. Swap operands → flag=5'b00011.
4. Hold in_ready=0 for 10 cycles in DONE while pulsing in_valid → out_valid stays 1, outputs constant, out_ready=0, no new accept. Raise in_ready → IDLE next cycle.
5. Assert in_rst during the 2nd BUSY cycle → all outputs 0, out_valid=0, out_ready=1 immediately (asynchronous). The next request A=3, B=7 unsigned → flag=5'b01100.
6. DATA_WIDTH=8, CHUNK_WIDTH=8: A=8'h80, B=8'h7F → latency 1; signed LT=1, unsigned LTU=0, flag=5'b01001. With DATA_WIDTH=8, CHUNK_WIDTH=2 → same flags, latency 4.
